// File: rtl/frame_streamer_pkg.sv
// frame_streamer_pkg: shared dimensions, pixel typedefs and channel expansion.
package frame_streamer_pkg;

    localparam int unsigned H_PIXELS_DEF = 320;
    localparam int unsigned V_PIXELS_DEF = 240;
    localparam int unsigned ADDR_W_DEF   = 17;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef struct packed {
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } rgb101010_t;

    // Replicate the nibble into the top 8 bits so full scale maps near full scale.
    function automatic logic [9:0] expand4to10(input logic [3:0] c);
        return {c, c, 2'b00};
    endfunction

    function automatic rgb101010_t expand_rgb(input rgb444_t p);
        rgb101010_t q;
        q.r = expand4to10(p.r);
        q.g = expand4to10(p.g);
        q.b = expand4to10(p.b);
        return q;
    endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// stream_skid_fifo: 2-entry FIFO with synchronous flush; push allowed when full if popping.
module stream_skid_fifo #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem0;
    logic [WIDTH-1:0] r_mem1;
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == 2'd2);
    assign o_empty   = (r_count == 2'd0);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = r_rd_ptr ? r_mem1 : r_mem0;

    // Storage, pointers and occupancy; flush discards contents but keeps storage.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_mem0   <= '0;
            r_mem1   <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                if (r_wr_ptr) r_mem1 <= i_data;
                else          r_mem0 <= i_data;
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
        end
    end

endmodule

// File: rtl/frame_streamer.sv
// frame_streamer: scans the RGB444 frame buffer and emits RGB101010 Avalon-ST beats with
// sop/eop framing. Optional feature macro: FRAME_STREAMER_TEST_PATTERN_EN.
module frame_streamer
    import frame_streamer_pkg::*;
#(
    parameter int unsigned H_PIXELS = H_PIXELS_DEF,
    parameter int unsigned V_PIXELS = V_PIXELS_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_restart,
    input  logic              i_test_pattern,
    output logic [ADDR_W-1:0] o_rd_address,
    input  logic [11:0]       i_rd_data,
    output logic [29:0]       o_out_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_out_sop,
    output logic              o_out_eop,
    output logic              o_frame_done
);

    localparam int unsigned COL_W  = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int unsigned ROW_W  = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;
    localparam int unsigned FIFO_W = $bits(rgb101010_t) + 2;
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(H_PIXELS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(V_PIXELS - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_PIXELS * V_PIXELS - 1);

    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [ADDR_W-1:0] r_addr;
    logic              r_pipe_vld;
    logic              r_pipe_sop;
    logic              r_pipe_eop;
    logic [7:0]        r_pipe_col;
    logic [7:0]        r_pipe_row;
    logic              r_frame_done;

    logic              w_valid;
    logic              w_pop;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [1:0]        w_fifo_cnt;
    logic [2:0]        w_level;
    logic              w_issue;
    rgb444_t           w_pixel;
    logic [FIFO_W-1:0] w_push_word;
    logic [FIFO_W-1:0] w_head_word;

    assign w_valid = ~w_fifo_empty;
    assign w_pop   = w_valid & i_out_ready;

    // Occupancy counts the beat leaving this cycle so a ready sink sees one beat per cycle.
    assign w_fifo_cnt = w_fifo_full ? 2'd2 : (w_fifo_empty ? 2'd0 : 2'd1);
    assign w_level    = {1'b0, w_fifo_cnt} + {2'b00, r_pipe_vld} - {2'b00, w_pop};
    assign w_issue    = ~i_restart & (w_level < 3'd2);

    // Raster position and linear read address advance on each issued read.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
        end else if (i_restart) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
        end else if (w_issue) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
            r_addr <= (r_addr == ADDR_LAST) ? '0 : r_addr + 1'b1;
        end
    end

    // Tags travel alongside the one-cycle RAM latency.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pipe_vld <= 1'b0;
            r_pipe_sop <= 1'b0;
            r_pipe_eop <= 1'b0;
            r_pipe_col <= '0;
            r_pipe_row <= '0;
        end else begin
            r_pipe_vld <= w_issue;
            r_pipe_sop <= (r_col == '0) && (r_row == '0);
            r_pipe_eop <= (r_col == COL_LAST) && (r_row == ROW_LAST);
            r_pipe_col <= 8'(r_col);
            r_pipe_row <= 8'(r_row);
        end
    end

`ifdef FRAME_STREAMER_TEST_PATTERN_EN
    // Pattern replaces buffer data at FIFO write; framing and reads are unaffected.
    always_comb begin
        w_pixel = i_rd_data;
        if (i_test_pattern) begin
            w_pixel.r = r_pipe_col[7:4];
            w_pixel.g = r_pipe_row[7:4];
            w_pixel.b = r_pipe_col[3:0] ^ r_pipe_row[3:0];
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{i_test_pattern, r_pipe_col, r_pipe_row};

    // Buffer data only.
    always_comb begin
        w_pixel = i_rd_data;
    end
`endif

    assign w_push_word = {expand_rgb(w_pixel), r_pipe_sop, r_pipe_eop};

    stream_skid_fifo #(
        .WIDTH (FIFO_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (i_restart),
        .i_push  (r_pipe_vld),
        .i_data  (w_push_word),
        .i_pop   (w_pop),
        .o_data  (w_head_word),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Pulse after the eop beat transfers, unless the frame is being aborted.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_pop & w_head_word[0] & ~i_restart;
        end
    end

    // Head of FIFO drives the beat; outputs are zero while nothing is buffered.
    always_comb begin
        o_out_valid = w_valid;
        o_out_data  = '0;
        o_out_sop   = 1'b0;
        o_out_eop   = 1'b0;
        if (w_valid) begin
            o_out_data = w_head_word[FIFO_W-1:2];
            o_out_sop  = w_head_word[1];
            o_out_eop  = w_head_word[0];
        end
    end

    assign o_rd_address = r_addr;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_frame_streamer.sv
// tb_frame_streamer: randomized bench with a raster-order reference model.
module tb_frame_streamer;

    localparam int unsigned H    = 64;
    localparam int unsigned V    = 60;
    localparam int unsigned AW   = 17;
    localparam int unsigned NPIX = H * V;
`ifdef FRAME_STREAMER_TEST_PATTERN_EN
    localparam bit TP_EN = 1'b1;
`else
    localparam bit TP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          restart = 1'b0;
    logic          test_pattern = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] rd_address;
    logic [11:0]   rd_data = 12'h000;
    logic [29:0]   out_data;
    logic          out_valid;
    logic          out_sop;
    logic          out_eop;
    logic          frame_done;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    frame_streamer #(
        .H_PIXELS (H),
        .V_PIXELS (V),
        .ADDR_W   (AW)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_restart      (restart),
        .i_test_pattern (test_pattern),
        .o_rd_address   (rd_address),
        .i_rd_data      (rd_data),
        .o_out_data     (out_data),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_out_sop      (out_sop),
        .o_out_eop      (out_eop),
        .o_frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // Frame buffer: registered read, content is the low 12 address bits.
    always @(posedge clk) rd_data <= rd_address[11:0];

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned exp10(input int unsigned c);
        return c * 68;  // {c, c, 2'b00}
    endfunction

    function automatic logic [29:0] model_data(input int unsigned a, input logic tp);
        int unsigned col = a % H;
        int unsigned row = a / H;
        int unsigned pix = a % 4096;
        int unsigned r = (pix / 256) % 16;
        int unsigned g = (pix / 16) % 16;
        int unsigned b = pix % 16;
        if (tp && TP_EN) begin
            r = (col / 16) % 16;
            g = (row / 16) % 16;
            b = (col % 16) ^ (row % 16);
        end
        return 30'(exp10(r) * 1048576 + exp10(g) * 1024 + exp10(b));
    endfunction

    // Monitor state: exp_idx is the number of beats accepted since the last reset/restart.
    int unsigned exp_idx = 0;
    int unsigned n_acc = 0;
    int unsigned n_eop = 0;
    int unsigned n_fd = 0;
    int unsigned mon_addr;
    logic        mon_eop;
    logic        mon_acc;
    logic        exp_fd = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_word = '0;
    logic [29:0] tp_seen = '0;
    localparam int unsigned TP_ADDR = 'h34 * H + 'h12;

    always @(negedge clk) begin
        if (reset) begin
            chk_eq("rst_valid", 64'(out_valid), 64'd0);
            chk_eq("rst_sop", 64'(out_sop), 64'd0);
            chk_eq("rst_eop", 64'(out_eop), 64'd0);
            chk_eq("rst_data", 64'(out_data), 64'd0);
            chk_eq("rst_frame_done", 64'(frame_done), 64'd0);
            chk_eq("rst_rd_address", 64'(rd_address), 64'd0);
            exp_idx    = 0;
            exp_fd     = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk_eq("frame_done", 64'(frame_done), 64'(exp_fd));
            if (frame_done) n_fd++;
            mon_addr = exp_idx % NPIX;
            mon_eop  = (mon_addr == NPIX - 1);
            if (prev_stall) begin
                chk_eq("hold_valid", 64'(out_valid), 64'd1);
                chk_eq("hold_beat", 64'({out_data, out_sop, out_eop}), 64'(prev_word));
            end
            if (out_valid) begin
                chk_eq("beat_data", 64'(out_data), 64'(model_data(mon_addr, test_pattern)));
                chk_eq("beat_sop", 64'(out_sop), 64'(mon_addr == 0));
                chk_eq("beat_eop", 64'(out_eop), 64'(mon_eop));
                if (mon_addr == TP_ADDR) tp_seen = out_data;
            end
            mon_acc = out_valid & out_ready;
            exp_fd  = mon_acc & mon_eop & ~restart;
            if (mon_acc) begin
                n_acc++;
                exp_idx++;
                if (mon_eop) n_eop++;
            end
            if (restart) exp_idx = 0;
            prev_stall = out_valid & ~out_ready & ~restart;
            prev_word  = {out_data, out_sop, out_eop};
        end
    end

    task automatic wait_acc(input string tag, input int unsigned n, input int unsigned bound,
                            input bit rnd);
        int unsigned base = n_acc;
        int unsigned cyc = 0;
        while ((n_acc - base) < n && cyc < bound) begin
            @(posedge clk);
            #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            cyc++;
        end
        chk_eq(tag, 64'((n_acc - base) >= n), 64'd1);
    endtask

    task automatic wait_idx(input string tag, input int unsigned n, input int unsigned bound);
        int unsigned cyc = 0;
        while (exp_idx < n && cyc < bound) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk_eq(tag, 64'(exp_idx >= n), 64'd1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned base;
        int unsigned gaps;
        int unsigned eop0;
        int unsigned fd0;
        int unsigned acc0;

        // Power-up, sustained streaming through one frame plus the wrap.
        repeat (3) @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        base      = n_acc;
        @(posedge clk);
        @(negedge clk);
        chk_eq("lat_e0_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk_eq("lat_e1_valid", 64'(out_valid), 64'd1);
        chk_eq("lat_e1_sop", 64'(out_sop), 64'd1);
        gaps = 0;
        for (int c = 0; c < int'(NPIX) + 50 && (n_acc - base) < NPIX + 1; c++) begin
            @(negedge clk);
            if (!out_valid) gaps++;
        end
        chk_eq("frame1_len", 64'((n_acc - base) >= NPIX + 1), 64'd1);
        chk_eq("frame1_gaps", 64'(gaps), 64'd0);
        repeat (2) @(negedge clk);
        chk_eq("frame1_eops", 64'(n_eop), 64'd1);
        chk_eq("frame1_done", 64'(n_fd), 64'd1);

        // Two frames under random backpressure.
        @(posedge clk);
        #1 restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
        eop0 = n_eop;
        fd0  = n_fd;
        wait_acc("rand_len", 2 * NPIX, 8 * NPIX, 1'b1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rand_eops", 64'(n_eop - eop0), 64'd2);
        chk_eq("rand_done", 64'(n_fd - fd0), 64'd2);

        // Reset, then hold off the sink: reads must stop two ahead.
        reset     = 1'b1;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        acc0 = n_acc;
        for (int c = 0; c < 10 && !out_valid; c++) @(negedge clk);
        chk_eq("stall_first_valid", 64'(out_valid), 64'd1);
        repeat (20) @(negedge clk);
        chk_eq("stall_rd_address", 64'(rd_address), 64'd2);
        chk_eq("stall_valid", 64'(out_valid), 64'd1);
        chk_eq("stall_no_accept", 64'(n_acc - acc0), 64'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;

        // Reset mid-frame for three cycles.
        wait_idx("reach_2000", 2000, 3 * NPIX);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_eq("rst2_e0_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk_eq("rst2_e1_valid", 64'(out_valid), 64'd1);
        chk_eq("rst2_e1_sop", 64'(out_sop), 64'd1);

        // Restart coinciding with the transfer of beat 1000.
        wait_idx("reach_1000", 1000, 3 * NPIX);
        chk_eq("rs_valid", 64'(out_valid), 64'd1);
        acc0    = n_acc;
        fd0     = n_fd;
        restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
        chk_eq("rs_counted", 64'(n_acc - acc0), 64'd1);
        @(negedge clk);
        chk_eq("rs_r0_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk_eq("rs_r1_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk_eq("rs_r2_valid", 64'(out_valid), 64'd1);
        chk_eq("rs_r2_sop", 64'(out_sop), 64'd1);
        chk_eq("rs_no_done", 64'(n_fd - fd0), 64'd0);

        // Test pattern through pixel (col 0x12, row 0x34).
        @(posedge clk);
        #1 restart = 1'b1;
        @(posedge clk);
        #1;
        restart      = 1'b0;
        test_pattern = 1'b1;
        wait_acc("tp_len", TP_ADDR + 1, 2 * NPIX, 1'b0);
`ifdef FRAME_STREAMER_TEST_PATTERN_EN
        chk_eq("tp_pixel", 64'(tp_seen), 64'({10'h044, 10'h0CC, 10'h198}));
`else
        chk_eq("tp_pixel", 64'(tp_seen), 64'({10'h374, 10'h044, 10'h088}));
`endif
        test_pattern = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/frame_streamer.md
# frame_streamer

Avalon-ST source that scans the 320x240 RGB444 frame buffer on the VGA-side clock and emits one 30-bit RGB101010 beat per pixel with start/end-of-packet framing. Sits between the frame buffer read port and the pixel filter / convolution / scaler chain. Replaces ad-hoc row/col counters with a proper ready/valid source that tolerates the buffer's 1-cycle read latency under backpressure.

## Interface
- `H_PIXELS`, 320, pixels per line
- `V_PIXELS`, 240, lines per frame
- `ADDR_W`, 17, frame buffer address width; must satisfy 2^ADDR_W >= H_PIXELS*V_PIXELS
- `clk`  in  1  pixel clock (25 MHz VGA domain); all logic on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `restart`  in  1  synchronous pulse; aborts the current frame, next beat is pixel (0,0)
- `test_pattern`  in  1  selects built-in pattern (honoured only with the macro below)
- `rd_address`  out  ADDR_W  frame buffer read address
- `rd_data`  in  12  frame buffer q, {R[3:0],G[3:0],B[3:0]}, valid exactly 1 cycle after the address
- `out_data`  out  30  {R10,G10,B10}
- `out_valid`  out  1  beat available
- `out_ready`  in  1  sink accepts beat
- `out_sop`  out  1  high with pixel (0,0)
- `out_eop`  out  1  high with pixel (H_PIXELS-1, V_PIXELS-1)
- `frame_done`  out  1  one-cycle pulse after the eop beat is accepted

## Operation
- Read side: `col`/`row` counters, `rd_address` = row*H_PIXELS+col kept as an incrementing linear counter (no multiplier). A read is issued when FIFO occupancy + reads in flight < 2. Issue advances col; col wraps at H_PIXELS-1 to 0 and increments row; row wraps at V_PIXELS-1 to 0 (frames are back-to-back, no idle gap).
- Each issued read carries sop/eop tags through a 1-stage pipe alongside the RAM latency, then writes {pixel, sop, eop} into a 2-entry FIFO.
- Expansion: each 4-bit channel c -> {c, c, 2'b00} (10 bits). 4'hF -> 10'h3FC, 4'h0 -> 0.
- Output: `out_valid` = FIFO non-empty; head drives data/sop/eop. Transfer when `out_valid & out_ready`. While valid and not ready, data/sop/eop held stable; valid never drops without a transfer.
- FIFO full: no new read issued; in-flight read always has a free slot (guaranteed by the issue rule). Never overflows, never drops.
- `restart`: FIFO and in-flight tag flushed, counters to 0, `frame_done` not pulsed. A beat accepted in the same cycle counts as delivered; the next beat is sop. `restart` during `reset` ignored.
- `reset` mid-frame: all state cleared immediately; behaves as power-up.
- Reset values: `rd_address` 0, `out_valid` 0, `out_sop` 0, `out_eop` 0, `out_data` 0, `frame_done` 0.

## Timing
- Edge E0 = first rising edge with `reset` low: read of address 0 issued (rd_address already 0).
- `rd_data` captured at E1; `out_valid`=1 with sop after E1 (i.e. visible in cycle E1–E2).
- With `out_ready` held high: one beat per cycle, sustained; eop beat of a frame immediately followed by sop of the next.
- `frame_done` high for the cycle after the eop transfer edge.
- After `restart` at edge R: first new beat valid after R+2 (same as power-up).

## Configuration
- `FRAME_STREAMER_TEST_PATTERN_EN`: when defined and `test_pattern`=1, pixel data replaced at FIFO write by R=col[7:4], G=row[7:4], B=col[3:0]^row[3:0] (then expanded); reads and framing unchanged. `test_pattern` sampled per beat. When undefined, `test_pattern` is ignored and only buffer data is output.

## Structure
- `frame_streamer_pkg`: default dimension constants, `rgb444_t`/`rgb101010_t` typedefs, `expand4to10` function.
- One sub-module: `stream_skid_fifo` (2-entry, parameterised width, push/pop/flush, full/empty).

## Test plan
- Reset release, ready=1, RAM model address->data (data = addr[11:0]) -> first beat after E1, sop=1, data = expand(12'h000); beat 319 data from addr 319; beat 76799 eop=1; frame_done pulses once; beat 76800 sop=1, addr wraps to 0.
- Random `out_ready` (50%) over 2 frames -> every beat in address order, no gaps/duplicates, data stable while stalled, exactly 2 eop and 2 frame_done.
- `out_ready`=0 for 20 cycles after first valid -> at most 2 reads outstanding+buffered, rd_address stops at 2, no overflow.
- `restart` at pixel 1000 coinciding with a transfer -> that beat counted, next beat is address 0 with sop, no frame_done.
- Assert `reset` at pixel 5000 for 3 cycles -> all outputs 0 during reset, resumes from address 0 with sop.
- Macro defined, test_pattern=1, pixel (col=0x12,row=0x34) -> out_data = {expand(1),expand(3),expand(6)}; macro undefined -> buffer data.
